// File: rtl/dmem_access_seq_if.sv
// Data-memory port bundle between the access sequencer (master) and the memory (slave).
// The request side is driven by the master; ack and read data come back from the slave.
interface dmem_access_seq_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_access_seq.sv
// Load/store access sequencer: turns decoder MemRead/MemWrite into a req/ack memory access,
// stalls the pipeline while outstanding, and aborts accesses that are never acknowledged.
module dmem_access_seq #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid,
  output logic              timeout_err,
  dmem_access_seq_if.master mem
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              r_terr;

  logic              w_req_in;
  logic              w_last;

  assign w_req_in = mem_read_i | mem_write_i;
  assign w_last   = (r_cnt == CNT_LAST);

  // Stall must cover the request cycle itself, so it cannot wait for the state register.
  assign stall = ((r_state == S_IDLE) & w_req_in) | (r_state == S_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_terr   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rvalid <= 1'b0;
          if (w_req_in) begin
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_we    <= mem_write_i;
            r_cnt   <= '0;
            r_req   <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Ack is checked first so an ack on the last allowed cycle still completes cleanly.
          if (mem.mem_ack) begin
            if (!r_we) begin
              r_rdata <= mem.mem_rdata;
            end
            r_rvalid <= ~r_we;
            r_req    <= 1'b0;
            r_state  <= S_DONE;
          end else if (w_last) begin
            r_terr   <= 1'b1;
            r_rdata  <= '0;
            r_rvalid <= ~r_we;
            r_req    <= 1'b0;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_rvalid <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_req    <= 1'b0;
          r_rvalid <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign mem.mem_req   = r_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;

  assign rdata_o     = r_rdata;
  assign rdata_valid = r_rvalid;
  assign timeout_err = r_terr;

endmodule

// File: tb/tb_dmem_access_seq.sv
// Bench for dmem_access_seq: a cycle-numbered transaction model checked every cycle,
// plus directed lw/sw/timeout/reset scenarios with literal expectations.
module tb_dmem_access_seq;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd = 1'b0;
  logic          wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          stall;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          terr;

  always #5 clk = ~clk;

  dmem_access_seq_if #(.DATA_W(DW), .ADDR_W(AW)) mem ();

  dmem_access_seq #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_read_i  (rd),
    .mem_write_i (wr),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .stall       (stall),
    .rdata_o     (rdata),
    .rdata_valid (rvalid),
    .timeout_err (terr),
    .mem         (mem)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted access occupies WAIT cycles t0+1.., and DONE is the cycle
  // after the ack or after the TIMEOUT-th unacknowledged WAIT cycle.
  int            n = 0;
  bit            m_acc = 1'b0;
  int            m_t0 = 0;
  int            m_done = -1;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  bit            m_terr = 1'b0;

  always @(negedge clk) begin
    bit in_wait, done_now, idle;
    n++;
    if (reset) begin
      m_acc = 1'b0; m_done = -1; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      m_rdata = '0; m_terr = 1'b0;
      chk("rst_mem_req", mem.mem_req, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_terr", terr, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_addr", mem.mem_addr, 0);
      chk("rst_stall", stall, rd | wr);
    end else begin
      in_wait  = m_acc && (n > m_t0);
      done_now = (n == m_done);
      idle     = !in_wait && !done_now;
      chk("stall", stall, in_wait || (idle && (rd || wr)));
      chk("mem_req", mem.mem_req, in_wait);
      chk("mem_we", mem.mem_we, m_we);
      chk("mem_addr", mem.mem_addr, m_addr);
      chk("mem_wdata", mem.mem_wdata, m_wdata);
      chk("rdata_valid", rvalid, done_now && !m_we);
      chk("rdata_o", rdata, m_rdata);
      chk("timeout_err", terr, m_terr);
      if (idle && (rd || wr)) begin
        m_acc = 1'b1; m_t0 = n; m_we = wr; m_addr = addr; m_wdata = wdata;
      end else if (in_wait) begin
        if (mem.mem_ack) begin
          m_acc = 1'b0; m_done = n + 1;
          if (!m_we) m_rdata = mem.mem_rdata;
        end else if (n - m_t0 == TO) begin
          m_acc = 1'b0; m_done = n + 1; m_terr = 1'b1; m_rdata = '0;
        end
      end
    end
  end

  // One access: request for one cycle, ack on WAIT cycle k (k<0: never), report what was seen.
  task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input int k, input logic [31:0] rdv,
                        output int n_stall, output int n_req, output bit we_seen,
                        output bit rv_done, output logic [31:0] rd_done, output bit stall_done);
    n_stall = 0; n_req = 0; we_seen = 1'b0;
    @(posedge clk); #1 rd = r; wr = w; addr = a; wdata = d;
    @(negedge clk); if (stall) n_stall++;
    @(posedge clk); #1 rd = 1'b0; wr = 1'b0;
    for (int i = 0; i < TO; i++) begin
      mem.mem_ack   = (i == k);
      mem.mem_rdata = (i == k) ? rdv : 32'h0BAD_0BAD;
      @(negedge clk);
      if (stall) n_stall++;
      if (mem.mem_req) n_req++;
      if (i == 0) we_seen = mem.mem_we;
      @(posedge clk); #1 mem.mem_ack = 1'b0;
      if (i == k) break;
    end
    @(negedge clk);
    rv_done = rvalid; rd_done = rdata; stall_done = stall;
    $display("access rd=%0b wr=%0b addr=%0h k=%0d: stall=%0d req=%0d we=%0b rvalid=%0b rdata=%0h",
             r, w, a, k, n_stall, n_req, we_seen, rv_done, rd_done);
  endtask

  task automatic reset_mid_wait(input logic [31:0] a);
    @(posedge clk); #1 rd = 1'b1; addr = a;
    @(posedge clk); #1 rd = 1'b0;
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    #1;
    chk("midrst_req", mem.mem_req, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_terr", terr, 0);
    $display("reset mid-WAIT addr=%0h: mem_req=%0b stall=%0b terr=%0b", a, mem.mem_req, stall, terr);
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    int ns, nr;
    bit we, rv, sd;
    logic [31:0] rdo;
    reset = 1'b1;
    mem.mem_ack = 1'b0;
    mem.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    reset_mid_wait(32'h44);

    access(1, 0, 32'h40, 32'h0, 0, 32'hDEADBEEF, ns, nr, we, rv, rdo, sd);
    chk("lw0_stall_cycles", ns, 2);
    chk("lw0_req_cycles", nr, 1);
    chk("lw0_rvalid", rv, 1);
    chk("lw0_rdata", rdo, 32'hDEADBEEF);
    chk("lw0_done_stall", sd, 0);

    access(0, 1, 32'h80, 32'h12345678, 3, 32'h0, ns, nr, we, rv, rdo, sd);
    chk("sw3_req_cycles", nr, 4);
    chk("sw3_stall_cycles", ns, 5);
    chk("sw3_we", we, 1);
    chk("sw3_rvalid", rv, 0);
    chk("sw3_done_stall", sd, 0);

    access(1, 0, 32'h100, 32'h0, TO - 1, 32'hCAFEF00D, ns, nr, we, rv, rdo, sd);
    chk("lastack_req_cycles", nr, 15);
    chk("lastack_rvalid", rv, 1);
    chk("lastack_rdata", rdo, 32'hCAFEF00D);
    chk("lastack_terr", terr, 0);

    access(1, 0, 32'h104, 32'h0, -1, 32'h0, ns, nr, we, rv, rdo, sd);
    chk("to_req_cycles", nr, 15);
    chk("to_stall_cycles", ns, 16);
    chk("to_rvalid", rv, 1);
    chk("to_rdata", rdo, 0);
    chk("to_terr", terr, 1);
    @(posedge clk); #1 mem.mem_ack = 1'b1; mem.mem_rdata = 32'h5555AAAA;
    @(negedge clk);
    chk("late_ack_req", mem.mem_req, 0);
    chk("late_ack_rvalid", rvalid, 0);
    chk("late_ack_rdata", rdata, 0);
    $display("late ack: mem_req=%0b rvalid=%0b rdata=%0h terr=%0b", mem.mem_req, rvalid, rdata, terr);
    @(posedge clk); #1 mem.mem_ack = 1'b0;

    access(1, 0, 32'h200, 32'h0, 1, 32'h11111111, ns, nr, we, rv, rdo, sd);
    chk("b2b_lw_rdata", rdo, 32'h11111111);
    access(0, 1, 32'h204, 32'h22222222, 0, 32'h0, ns, nr, we, rv, rdo, sd);
    chk("b2b_sw_stall_cycles", ns, 2);
    chk("b2b_sw_we", we, 1);
    chk("b2b_sw_addr", mem.mem_addr, 32'h204);
    access(1, 1, 32'h208, 32'h33333333, 0, 32'h0, ns, nr, we, rv, rdo, sd);
    chk("both_we", we, 1);
    chk("both_rvalid", rv, 0);
    chk("both_wdata", mem.mem_wdata, 32'h33333333);
    chk("sticky_terr", terr, 1);

    reset_mid_wait(32'h300);
    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
